// File: rtl/float_pkg.sv
// float_pkg: encodings and constants shared by the FPU datapath blocks
package float_pkg;
  typedef enum logic [1:0] {RM_RNE = 2'b00, RM_RD = 2'b01, RM_RU = 2'b10, RM_RZ = 2'b11} rm_e;
  typedef enum logic [2:0] {S_IDLE, S_PREP, S_ITER, S_ROUND, S_DONE} state_e;
  localparam logic [31:0] QNAN    = 32'h7fc00000;
  localparam logic [7:0]  INF_EXP = 8'hff;
  localparam logic [31:0] MAX_FIN = 32'h7f7fffff;
  localparam int          BIAS    = 127;
endpackage

// File: rtl/float_div_seq_if.sv
// float_div_seq_if: operand bus and start/busy/ready handshake of the sequential divider
interface float_div_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic [1:0]  rm;
  logic [31:0] s;
  logic        busy;
  logic        ready;
  modport master (output start, a, b, rm, input s, busy, ready);
  modport slave (input start, a, b, rm, output s, busy, ready);
endinterface

// File: rtl/float_div_pack.sv
// float_div_pack: normalises, rounds and range-checks the raw quotient into a binary32 word
module float_div_pack
  import float_pkg::*;
(
  input  logic              sign,
  input  logic signed [9:0] exp10,
  input  logic [25:0]       q,
  input  logic [25:0]       r,
  input  rm_e               rm,
  output logic [31:0]       word
);
  logic [22:0] mf, frac;
  logic guard, sticky, inc, carry, to_inf;
  logic signed [9:0] e_n, e_r;
  always_comb begin
    mf = q[25] ? q[24:2] : q[23:1];
    guard = q[25] ? q[1] : q[0];
    sticky = (q[25] & q[0]) | (|r);
    e_n = q[25] ? exp10 : exp10 - 10'sd1;
    inc = rm == RM_RNE ? guard & (sticky | mf[0]) :
          rm == RM_RD  ? (guard | sticky) & sign :
          rm == RM_RU  ? (guard | sticky) & ~sign : 1'b0;
    // the hidden one is implicit, so a carry out of the fraction means 2.0
    {carry, frac} = {1'b0, mf} + {23'd0, inc};
    e_r = carry ? e_n + 10'sd1 : e_n;
    to_inf = (rm == RM_RNE) | ((rm == RM_RD) & sign) | ((rm == RM_RU) & ~sign);
    word = e_r >= 10'sd255 ? {sign, to_inf ? {INF_EXP, 23'd0} : MAX_FIN[30:0]} :
           e_r <= 10'sd0   ? {sign, 31'd0} : {sign, e_r[7:0], frac};
  end
endmodule

// File: rtl/float_div_seq.sv
// float_div_seq: sequential binary32 divider, radix-2 restoring loop, fixed 29-cycle latency
module float_div_seq
  import float_pkg::*;
(
  input logic            clk,
  input logic            rst,
  float_div_seq_if.slave bus
);
  state_e state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d, s_q, s_d;
  rm_e rm_q, rm_d;
  logic [25:0] r_q, r_d, q_q, q_d, fb;
  logic [7:0] ea, eb;
  logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign, ge, spec;
  logic signed [9:0] exp10;
  logic [31:0] spec_word, pack_word;
  float_div_pack u_pack (.sign(sign), .exp10(exp10), .q(q_q), .r(r_q), .rm(rm_q), .word(pack_word));
  always_comb begin
    ea = a_q[30:23];
    eb = b_q[30:23];
    a_nan = (&ea) & (|a_q[22:0]);
    b_nan = (&eb) & (|b_q[22:0]);
    a_inf = (&ea) & ~(|a_q[22:0]);
    b_inf = (&eb) & ~(|b_q[22:0]);
    a_zero = ~(|ea);
    b_zero = ~(|eb);
    sign = a_q[31] ^ b_q[31];
    exp10 = $signed({2'b00, ea}) - $signed({2'b00, eb}) + 10'(BIAS);
    spec = a_nan | b_nan | a_inf | b_inf | a_zero | b_zero;
    spec_word = (a_nan | b_nan | (a_inf & b_inf) | (a_zero & b_zero)) ? QNAN :
                (a_inf | b_zero) ? {sign, INF_EXP, 23'd0} : {sign, 31'd0};
    fb = {3'b001, b_q[22:0]};
    ge = r_q >= fb;
    state_d = state_q;
    cnt_d = cnt_q;
    a_d = a_q;
    b_d = b_q;
    rm_d = rm_q;
    r_d = r_q;
    q_d = q_q;
    s_d = s_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        state_d = bus.start ? S_PREP : S_IDLE;
        a_d = bus.start ? bus.a : a_q;
        b_d = bus.start ? bus.b : b_q;
        rm_d = bus.start ? rm_e'(bus.rm) : rm_q;
      end
      S_PREP: begin
        state_d = S_ITER;
        r_d = {3'b001, a_q[22:0]};
        q_d = '0;
        cnt_d = 5'd25;
      end
      S_ITER: begin
        r_d = (ge ? r_q - fb : r_q) << 1;
        q_d = {q_q[24:0], ge};
        cnt_d = cnt_q == 5'd0 ? 5'd0 : cnt_q - 5'd1;
        state_d = cnt_q == 5'd0 ? S_ROUND : S_ITER;
      end
      S_ROUND: begin
        s_d = spec ? spec_word : pack_word;
        state_d = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q <= '0;
      a_q <= '0;
      b_q <= '0;
      rm_q <= RM_RNE;
      r_q <= '0;
      q_q <= '0;
      s_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      a_q <= a_d;
      b_q <= b_d;
      rm_q <= rm_d;
      r_q <= r_d;
      q_q <= q_d;
      s_q <= s_d;
    end
  end
  assign bus.s = s_q;
  assign bus.busy = state_q inside {S_PREP, S_ITER, S_ROUND};
  assign bus.ready = state_q == S_DONE;
endmodule

// File: tb/tb_float_div_seq.sv
// tb_float_div_seq: directed vectors with hand-computed quotients plus handshake/latency cases
module tb_float_div_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n_vec = 0;
  int n_bad = 0;
  float_div_seq_if bus ();
  float_div_seq dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rm);
    bus.start = 1'b1;
    bus.a = a;
    bus.b = b;
    bus.rm = rm;
    @(negedge clk);
    bus.start = 1'b0;
    bus.a = $urandom;
    bus.b = $urandom;
    bus.rm = 2'($urandom);
  endtask
  task automatic op(input string tag, input logic [31:0] a, input logic [31:0] b,
                    input logic [1:0] rm, input logic [31:0] exp_s);
    int cyc, nb;
    @(negedge clk);
    launch(a, b, rm);
    cyc = 1;
    nb = 0;
    while (!bus.ready && cyc < 40) begin
      nb += int'(bus.busy);
      @(negedge clk);
      cyc++;
    end
    chk({tag, " s"}, bus.s, exp_s);
    chk({tag, " lat"}, 32'(cyc), 32'd29);
    chk({tag, " busy_cycles"}, 32'(nb), 32'd28);
    chk({tag, " busy_at_ready"}, 32'(bus.busy), 32'd0);
  endtask
  initial begin
    int cyc, nr;
    bus.start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.rm = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst s", bus.s, 32'h0);
    chk("rst busy", 32'(bus.busy), 32'd0);
    chk("rst ready", 32'(bus.ready), 32'd0);
    op("6/2 rne", 32'h40c00000, 32'h40000000, 2'b00, 32'h40400000);
    op("1/3 rne", 32'h3f800000, 32'h40400000, 2'b00, 32'h3eaaaaab);
    op("1/3 rz", 32'h3f800000, 32'h40400000, 2'b11, 32'h3eaaaaaa);
    op("1/3 ru", 32'h3f800000, 32'h40400000, 2'b10, 32'h3eaaaaab);
    op("1/3 rd", 32'h3f800000, 32'h40400000, 2'b01, 32'h3eaaaaaa);
    op("-1/3 rd", 32'hbf800000, 32'h40400000, 2'b01, 32'hbeaaaaab);
    op("-6/2", 32'hc0c00000, 32'h40000000, 2'b00, 32'hc0400000);
    op("1/0", 32'h3f800000, 32'h00000000, 2'b00, 32'h7f800000);
    op("-0/-0", 32'h80000000, 32'h80000000, 2'b00, 32'h7fc00000);
    op("-inf/2", 32'hff800000, 32'h40000000, 2'b00, 32'hff800000);
    op("nan/1", 32'h7f800001, 32'h3f800000, 2'b00, 32'h7fc00000);
    op("inf/inf", 32'h7f800000, 32'hff800000, 2'b00, 32'h7fc00000);
    op("-2/inf", 32'hc0000000, 32'h7f800000, 2'b00, 32'h80000000);
    op("denorm/1", 32'h00400000, 32'h3f800000, 2'b00, 32'h00000000);
    op("max/0.5 rne", 32'h7f7fffff, 32'h3f000000, 2'b00, 32'h7f800000);
    op("max/0.5 rz", 32'h7f7fffff, 32'h3f000000, 2'b11, 32'h7f7fffff);
    op("-max/0.5 ru", 32'hff7fffff, 32'h3f000000, 2'b10, 32'hff7fffff);
    op("-max/0.5 rd", 32'hff7fffff, 32'h3f000000, 2'b01, 32'hff800000);
    op("minnorm/2", 32'h00800000, 32'h40000000, 2'b00, 32'h00000000);
    // a second start mid-operation must be dropped, not queued
    @(negedge clk);
    launch(32'h40c00000, 32'h40000000, 2'b00);
    cyc = 1;
    while (!bus.ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.start = cyc == 10;
    end
    bus.start = 1'b0;
    chk("ignore lat", 32'(cyc), 32'd29);
    chk("ignore s", bus.s, 32'h40400000);
    nr = 0;
    repeat (35) begin
      @(negedge clk);
      nr += int'(bus.ready);
    end
    chk("ignore no_second", 32'(nr), 32'd0);
    // start in the DONE cycle is accepted immediately
    @(negedge clk);
    launch(32'h40c00000, 32'h40000000, 2'b00);
    cyc = 1;
    while (!bus.ready && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b first lat", 32'(cyc), 32'd29);
    chk("b2b first s", bus.s, 32'h40400000);
    launch(32'h3f800000, 32'h40400000, 2'b00);
    cyc++;
    while (!bus.ready && cyc < 80) begin
      @(negedge clk);
      cyc++;
    end
    chk("b2b second lat", 32'(cyc), 32'd58);
    chk("b2b second s", bus.s, 32'h3eaaaaab);
    // reset mid-operation aborts without a ready pulse
    @(negedge clk);
    launch(32'h40c00000, 32'h40000000, 2'b00);
    repeat (14) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort s", bus.s, 32'h0);
    chk("abort busy", 32'(bus.busy), 32'd0);
    nr = 0;
    repeat (40) begin
      @(negedge clk);
      nr += int'(bus.ready);
    end
    chk("abort no_ready", 32'(nr), 32'd0);
    op("after abort", 32'h3f800000, 32'h3f800000, 2'b00, 32'h3f800000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
